keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable model of a 4x4 matrix keypad. It is the responder to the keypad scanner: the scanner drives columns, and this block returns row contacts.
- It accepts press/release requests over a valid/ready handshake.
- It emulates contact bounce with an LFSR on every press and release.
- Used on-chip or in benches so the scanner, debouncer and seven-segment path can be exercised without a physical keypad.

Parameters:
- BOUNCE_CYCLES, 40, number of int_osc cycles the contact bounces after a press or release (legal range 1..255).
- LFSR_SEED, 8'hA5, reset value of the bounce LFSR (must be nonzero).

Ports:
- int_osc  input  1  system clock.
- nrst  input  1  reset; one clock; reset is asynchronous and active-low.
- column_signals  input  4  column drive from the scanner; active-high; bit c = column c.
- row_d  output  4  row contacts back to the scanner; active-high; bit r = row r.
- key_valid  input  1  request valid.
- key_code  input  4  hex key for the request.
- key_press  input  1  1 = press, 0 = release.
- key_ready  output  1  block can accept a request this cycle.
- busy  output  1  a bounce window is in progress.
- held_key  output  4  code of the key currently pressed (0 when none).
- err  output  1  one-cycle pulse when a request is illegal for the current state.

Behaviour:
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states and transitions:
  - IDLE: no contact. A press transfer goes to BOUNCE_IN.
  - BOUNCE_IN: contact = lfsr[0] each cycle, for exactly BOUNCE_CYCLES cycles, then go to HELD.
  - HELD: contact = 1. A release transfer goes to BOUNCE_OUT.
  - BOUNCE_OUT: contact = lfsr[0], for exactly BOUNCE_CYCLES cycles, then go to IDLE (contact 0).
- Transfer occurs on the int_osc rising edge where key_valid & key_ready are both 1.
  - key_ready = 1 in IDLE and HELD, 0 in the bounce states.
  - The state changes on the edge after the transfer.
- Press transfer in IDLE: latch key_code into held_key and load the bounce counter with BOUNCE_CYCLES-1.
- Illegal requests (each is consumed, leaves state unchanged, and pulses err for one cycle on the next cycle):
  - Release transfer in IDLE.
  - Press transfer in HELD.
- Release transfer in HELD: key_code is ignored; the latched key is released. held_key clears to 0 on entry to IDLE.
- busy = 1 in BOUNCE_IN and BOUNCE_OUT, otherwise 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It steps every cycle regardless of state and loads LFSR_SEED on reset.
- row_d is combinational from registered contact and column_signals; zero latency, like a wire keypad.
  - row_d[r] = contact & (r == row(held_key)) & column_signals[col(held_key)].
  - Multiple columns asserted: the row still responds if the key's column is among them.
  - column_signals = 0 gives row_d = 0.
- Reset (async, any time, including mid-bounce):
  - State IDLE, contact 0, held_key 0, err 0, busy 0.
  - row_d = 0, key_ready = 1.
  - LFSR = LFSR_SEED, counter = 0.
- A request presented while key_ready = 0 is not transferred. The requester must hold key_valid and data stable until ready.

Decomposition:
- Package keypad_pkg holds:
  - The state enum (IDLE, BOUNCE_IN, HELD, BOUNCE_OUT).
  - Constant arrays KEY_ROW[16] and KEY_COL[16] encoding the key map.
  - The LFSR tap mask constant.
- One sub-module, bounce_lfsr: 8-bit LFSR with seed parameter; outputs the bit stream.

Test Plan:
- Reset then idle, column_signals 4'b0010 → row_d 4'b0000, key_ready 1, held_key 0, err 0.
- Press key 5, BOUNCE_CYCLES=4:
  - During bounce: busy 1 for exactly 4 cycles, key_ready 0, row_d[1] follows lfsr[0] while column_signals = 4'b0010.
  - After bounce: row_d = 4'b0010 steadily, held_key 5.
- Key 5 held, scanning columns 0001/0010/0100/1000 in turn → row_d 0000/0010/0000/0000. Key D held with column 1000 → row_d 1000.
- Release in HELD (key_code = 3) → 4 bounce cycles, then row_d 0 on every column, held_key 0, key_ready 1.
- Release in IDLE → err pulses for 1 cycle, no state change. Press 9 while key 5 is held → err pulse, held_key stays 5.
- Assert nrst=0 mid-BOUNCE_IN → immediately row_d 0, busy 0, key_ready 1. After release, a fresh press of key 0 gives the same bounce pattern as the first press after power-up (seed reloaded).

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator: FSM states,
// key-code to matrix-position map and the bounce LFSR polynomial.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BOUNCE_IN  = 2'd1,
    HELD       = 2'd2,
    BOUNCE_OUT = 2'd3
  } state_e;

  // x^8+x^6+x^5+x^4+1 as a mask over lfsr[7:0] for a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Indexed by key code 0..F.
  localparam logic [1:0] KEY_ROW [16] = '{
    2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
    2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3
  };
  localparam logic [1:0] KEY_COL [16] = '{
    2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
    2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd2
  };

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the contact-bounce noise source.
// bit_next is the value lfsr[0] takes at the coming edge, so a registered
// consumer sees the current lfsr[0] in the same cycle.
import keypad_pkg::*;

module bounce_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic int_osc,
  input  logic nrst,
  output logic bit_next
);

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = ^(lfsr_q & LFSR_TAPS);
  assign bit_next = feedback;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) lfsr_q <= SEED;
    else       lfsr_q <= {lfsr_q[6:0], feedback};
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: accepts press/release requests, bounces the
// contact for BOUNCE_CYCLES cycles on each edge, and drives row contacts.
import keypad_pkg::*;

module keypad_emulator #(
  parameter int         BOUNCE_CYCLES = 40,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       int_osc,
  input  logic       nrst,
  input  logic [3:0] column_signals,
  output logic [3:0] row_d,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_press,
  output logic       key_ready,
  output logic       busy,
  output logic [3:0] held_key,
  output logic       err
);

  localparam logic [7:0] CNT_LOAD = 8'(BOUNCE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q;
  logic       contact_q;
  logic [3:0] held_q;
  logic       err_q;
  logic       lfsr_bit_next;
  logic       transfer;
  logic       bounce_done;
  logic       next_bouncing;

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .int_osc  (int_osc),
    .nrst     (nrst),
    .bit_next (lfsr_bit_next)
  );

  assign transfer      = key_valid & key_ready;
  assign bounce_done   = (cnt_q == 8'd0);
  assign next_bouncing = (state_d == BOUNCE_IN) || (state_d == BOUNCE_OUT);

  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (transfer && key_press)  state_d = BOUNCE_IN;
      BOUNCE_IN:  if (bounce_done)            state_d = HELD;
      HELD:       if (transfer && !key_press) state_d = BOUNCE_OUT;
      BOUNCE_OUT: if (bounce_done)            state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state_q == IDLE) || (state_q == HELD);
    busy      = (state_q == BOUNCE_IN) || (state_q == BOUNCE_OUT);
  end

  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= 8'd0;
      contact_q <= 1'b0;
      held_q    <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      // A press is only legal from IDLE, a release only from HELD.
      err_q     <= transfer && (key_press == (state_q == HELD));
      contact_q <= (state_d == HELD) || (next_bouncing && lfsr_bit_next);

      if (next_bouncing && !busy)       cnt_q <= CNT_LOAD;
      else if (busy && !bounce_done)    cnt_q <= cnt_q - 8'd1;

      if (state_q == IDLE && transfer && key_press)  held_q <= key_code;
      else if (state_q == BOUNCE_OUT && bounce_done) held_q <= 4'd0;
    end
  end

  assign held_key = held_q;
  assign err      = err_q;

  // Zero-latency path from columns to rows, like a real switch matrix.
  always_comb begin
    row_d = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      row_d[r] = contact_q && (KEY_ROW[held_q] == 2'(r))
                 && column_signals[KEY_COL[held_q]];
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a cycle-level reference model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_keypad_emulator;

  localparam int         BOUNCE = 4;
  localparam logic [7:0] SEED   = 8'hA5;

  logic       int_osc = 1'b0;
  logic       nrst = 1'b1;
  logic [3:0] column_signals = 4'd0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_press = 1'b0;
  logic [3:0] row_d;
  logic       key_ready;
  logic       busy;
  logic [3:0] held_key;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 int_osc = ~int_osc;

  keypad_emulator #(.BOUNCE_CYCLES(BOUNCE), .LFSR_SEED(SEED)) dut (
    .int_osc        (int_osc),
    .nrst           (nrst),
    .column_signals (column_signals),
    .row_d          (row_d),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_press      (key_press),
    .key_ready      (key_ready),
    .busy           (busy),
    .held_key       (held_key),
    .err            (err)
  );

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
  endtask

  // ---------------- reference model ----------------
  int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  logic [7:0] m_lfsr;
  bit         m_down;
  int         m_left;
  logic [3:0] m_key;
  bit         m_err;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [3:0] exp_row(input bit contact, input logic [3:0] key, input logic [3:0] cols);
    logic [3:0] rows = 4'd0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (layout[rr][cc] == int'(key) && contact && cols[cc]) rows[rr] = 1'b1;
    return rows;
  endfunction

  always @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      m_lfsr <= SEED;
      m_down <= 1'b0;
      m_left <= 0;
      m_key  <= 4'd0;
      m_err  <= 1'b0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      m_err  <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1 && !m_down) m_key <= 4'd0;
      end else if (key_valid) begin
        if (key_press == m_down) m_err <= 1'b1;
        else begin
          m_down <= key_press;
          m_left <= BOUNCE;
          if (key_press) m_key <= key_code;
        end
      end
    end
  end

  always @(negedge int_osc) begin
    check("model_row_d", row_d, exp_row((m_left > 0) ? m_lfsr[0] : m_down, m_key, column_signals));
    check("model_ready", key_ready, m_left == 0);
    check("model_busy", busy, m_left > 0);
    check("model_held", held_key, m_key);
    check("model_err", err, m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge int_osc);
    #1;
  endtask

  task automatic request(input logic [3:0] code, input logic press);
    key_valid = 1'b1;
    key_code  = code;
    key_press = press;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    check("rst_row", row_d, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", key_ready, 1'b1);
    check("rst_held", held_key, 4'd0);
    check("rst_err", err, 1'b0);
    repeat (2) @(posedge int_osc);
    #1;
    nrst = 1'b1;
  endtask

  task automatic bounce_pattern(input int row, output logic [3:0] pat);
    pat = 4'd0;
    for (int i = 0; i < BOUNCE; i++) begin
      check("bounce_busy", busy, 1'b1);
      check("bounce_ready", key_ready, 1'b0);
      pat[i] = row_d[row];
      tick();
    end
    check("bounce_end_busy", busy, 1'b0);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!key_ready && n < 50) begin
      tick();
      n++;
    end
    check(name, key_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] scan_cols [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000};
  logic [3:0] scan_rows [6] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

  initial begin
    logic [3:0] pat;
    #1;
    do_reset();
    column_signals = 4'b0010;
    #1;
    check("idle_row", row_d, 4'd0);
    check("idle_ready", key_ready, 1'b1);
    check("idle_held", held_key, 4'd0);
    check("idle_err", err, 1'b0);

    // First press after reset: contact bits are lfsr[0] of A5's successors 4A,95,2A,54.
    request(4'h5, 1'b1);
    bounce_pattern(1, pat);
    check("press5_pattern", pat, 4'b0010);
    check("held5_row", row_d, 4'b0010);
    check("held5_key", held_key, 4'h5);

    for (int i = 0; i < 6; i++) begin
      column_signals = scan_cols[i];
      #1;
      check("scan5_row", row_d, scan_rows[i]);
      tick();
    end

    column_signals = 4'b0010;
    request(4'h9, 1'b1);
    check("press_in_held_err", err, 1'b1);
    check("press_in_held_key", held_key, 4'h5);
    check("press_in_held_row", row_d, 4'b0010);
    tick();
    check("press_in_held_err_clr", err, 1'b0);

    request(4'h3, 1'b0);
    bounce_pattern(1, pat);
    check("release_held", held_key, 4'd0);
    check("release_ready", key_ready, 1'b1);
    column_signals = 4'b1111;
    #1;
    check("release_row_all", row_d, 4'd0);

    request(4'h7, 1'b0);
    check("release_idle_err", err, 1'b1);
    check("release_idle_busy", busy, 1'b0);
    check("release_idle_held", held_key, 4'd0);
    tick();
    check("release_idle_err_clr", err, 1'b0);

    request(4'hD, 1'b1);
    wait_ready("keyd_settle");
    column_signals = 4'b1000;
    #1;
    check("keyd_row", row_d, 4'b1000);
    column_signals = 4'b0111;
    #1;
    check("keyd_other_cols", row_d, 4'd0);
    tick();
    request(4'h0, 1'b0);
    wait_ready("keyd_release");

    // Reset in the middle of a press bounce, then replay from power-up timing.
    column_signals = 4'b0010;
    request(4'h5, 1'b1);
    tick();
    check("mid_bounce_busy", busy, 1'b1);
    do_reset();
    request(4'h0, 1'b1);
    bounce_pattern(3, pat);
    check("press0_pattern", pat, 4'b0010);
    check("held0_row", row_d, 4'b1000);
    check("held0_key", held_key, 4'h0);
    request(4'h0, 1'b0);
    wait_ready("key0_release");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
